// File: rtl/dk_audio_mix_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : dk_audio_mix_sched_if
// Brief   : Sample tick, channel bus and mixed-sample outputs of the mixer.
//           Optional DK_AUDIO_MIX_MUTE_EN adds the per-channel mute vector.
// Revision: 1.0 - initial release
// ============================================================================
interface dk_audio_mix_sched_if #(
    parameter int NUM_CH = 4,
    parameter int GAIN_W = 8
);
    logic                       audio_clk_en;
    logic [NUM_CH*16-1:0]       ch_in;
    logic [NUM_CH*GAIN_W-1:0]   ch_gain;
`ifdef DK_AUDIO_MIX_MUTE_EN
    logic [NUM_CH-1:0]          ch_mute;
`endif
    logic [15:0]                mix_out;
    logic                       mix_valid;
    logic                       busy;
    logic                       overrun;

`ifdef DK_AUDIO_MIX_MUTE_EN
    modport master (output audio_clk_en, ch_in, ch_gain, ch_mute,
                    input  mix_out, mix_valid, busy, overrun);
    modport slave  (input  audio_clk_en, ch_in, ch_gain, ch_mute,
                    output mix_out, mix_valid, busy, overrun);
`else
    modport master (output audio_clk_en, ch_in, ch_gain,
                    input  mix_out, mix_valid, busy, overrun);
    modport slave  (input  audio_clk_en, ch_in, ch_gain,
                    output mix_out, mix_valid, busy, overrun);
`endif
endinterface
`default_nettype wire

// File: rtl/dk_audio_mix_sched.sv
`default_nettype none
// ============================================================================
// Module  : dk_audio_mix_sched
// Brief   : Time-multiplexed saturating mixer, one shared MAC stepped through
//           the channels per sample tick. Option macro: DK_AUDIO_MIX_MUTE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module dk_audio_mix_sched #(
    parameter int NUM_CH = 4,
    parameter int GAIN_W = 8
) (
    input  wire logic                clk,
    input  wire logic                reset,
    dk_audio_mix_sched_if.slave      bus
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int ACC_W = 16 + GAIN_W + $clog2(NUM_CH) + 1;

    localparam logic signed [ACC_W-1:0] C_RND = ACC_W'(1) <<< (GAIN_W - 2);
    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] C_MIN = -(ACC_W'(32768));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                     r_state_q,     w_state_d;
    logic [IDX_W-1:0]           r_idx_q,       w_idx_d;
    logic signed [ACC_W-1:0]    r_acc_q,       w_acc_d;
    logic [NUM_CH*16-1:0]       r_snap_in_q,   w_snap_in_d;
    logic [NUM_CH*GAIN_W-1:0]   r_snap_gain_q, w_snap_gain_d;
    logic signed [15:0]         r_mix_out_q,   w_mix_out_d;
    logic                       r_mix_valid_q, w_mix_valid_d;
    logic                       r_busy_q,      w_busy_d;
    logic                       r_overrun_q,   w_overrun_d;
`ifdef DK_AUDIO_MIX_MUTE_EN
    logic [NUM_CH-1:0]          r_snap_mute_q, w_snap_mute_d;
`endif

    logic signed [15:0]         w_sel_in;
    logic [GAIN_W-1:0]          w_sel_gain;
    logic signed [ACC_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]    w_rnd;
    logic signed [15:0]         w_sat;

    // The single shared multiplier: gain is zero-extended so it multiplies as a positive value.
    always_comb begin
        w_sel_in   = r_snap_in_q[int'(r_idx_q)*16 +: 16];
        w_sel_gain = r_snap_gain_q[int'(r_idx_q)*GAIN_W +: GAIN_W];
`ifdef DK_AUDIO_MIX_MUTE_EN
        if (r_snap_mute_q[r_idx_q]) begin
            w_sel_gain = '0;
        end
`endif
        w_prod = ACC_W'(w_sel_in) * ACC_W'($signed({1'b0, w_sel_gain}));
    end

    // Half-up rounding then clamp to the 16-bit signed range.
    always_comb begin
        w_rnd = (r_acc_q + C_RND) >>> (GAIN_W - 1);
        if (w_rnd > C_MAX) begin
            w_sat = 16'sh7FFF;
        end else if (w_rnd < C_MIN) begin
            w_sat = 16'sh8000;
        end else begin
            w_sat = w_rnd[15:0];
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_acc_d       = r_acc_q;
        w_snap_in_d   = r_snap_in_q;
        w_snap_gain_d = r_snap_gain_q;
        w_mix_out_d   = r_mix_out_q;
        w_mix_valid_d = 1'b0;
        w_overrun_d   = r_overrun_q;
`ifdef DK_AUDIO_MIX_MUTE_EN
        w_snap_mute_d = r_snap_mute_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                if (bus.audio_clk_en) begin
                    w_snap_in_d   = bus.ch_in;
                    w_snap_gain_d = bus.ch_gain;
`ifdef DK_AUDIO_MIX_MUTE_EN
                    w_snap_mute_d = bus.ch_mute;
`endif
                    w_acc_d       = '0;
                    w_idx_d       = '0;
                    w_state_d     = S_MAC;
                end
            end
            S_MAC: begin
                w_acc_d = r_acc_q + w_prod;
                if (r_idx_q == IDX_W'(NUM_CH - 1)) begin
                    w_idx_d   = '0;
                    w_state_d = S_OUT;
                end else begin
                    w_idx_d = r_idx_q + IDX_W'(1);
                end
            end
            S_OUT: begin
                w_mix_out_d   = w_sat;
                w_mix_valid_d = 1'b1;
                w_state_d     = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
        // A tick arriving while a mix is still running is dropped and flagged.
        if (bus.audio_clk_en && (r_state_q != S_IDLE)) begin
            w_overrun_d = 1'b1;
        end
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= S_IDLE;
            r_idx_q       <= '0;
            r_acc_q       <= '0;
            r_snap_in_q   <= '0;
            r_snap_gain_q <= '0;
            r_mix_out_q   <= '0;
            r_mix_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_overrun_q   <= 1'b0;
`ifdef DK_AUDIO_MIX_MUTE_EN
            r_snap_mute_q <= '0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_acc_q       <= w_acc_d;
            r_snap_in_q   <= w_snap_in_d;
            r_snap_gain_q <= w_snap_gain_d;
            r_mix_out_q   <= w_mix_out_d;
            r_mix_valid_q <= w_mix_valid_d;
            r_busy_q      <= w_busy_d;
            r_overrun_q   <= w_overrun_d;
`ifdef DK_AUDIO_MIX_MUTE_EN
            r_snap_mute_q <= w_snap_mute_d;
`endif
        end
    end

    assign bus.mix_out   = r_mix_out_q;
    assign bus.mix_valid = r_mix_valid_q;
    assign bus.busy      = r_busy_q;
    assign bus.overrun   = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dk_audio_mix_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_dk_audio_mix_sched
// Brief   : Scoreboard bench for dk_audio_mix_sched at NUM_CH=4, GAIN_W=8.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dk_audio_mix_sched;
    localparam int NUM_CH = 4;
    localparam int GAIN_W = 8;

    logic clk;
    logic reset;

    dk_audio_mix_sched_if #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W)) ifc ();

    dk_audio_mix_sched #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;

    logic signed [15:0] sb_q[$];
    logic signed [15:0] ch[NUM_CH];
    logic [GAIN_W-1:0]  g[NUM_CH];
    logic [NUM_CH-1:0]  mute;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer sum, floor((acc + 64) / 128), then clamp.
    function automatic logic signed [15:0] model_mix();
        longint acc;
        acc = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!mute[k]) acc += longint'(ch[k]) * longint'({56'd0, g[k]});
        end
        acc = (acc + 64) >>> 7;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    task automatic apply_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            ifc.ch_in[16*k +: 16]         = ch[k];
            ifc.ch_gain[GAIN_W*k +: GAIN_W] = g[k];
        end
`ifdef DK_AUDIO_MIX_MUTE_EN
        ifc.ch_mute = mute;
`endif
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            ch[k] = '0;
            g[k]  = '0;
        end
        mute = '0;
        apply_inputs();
    endtask

    // Every valid strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ifc.mix_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: mix_out=%0d with no pending mix", $signed(ifc.mix_out));
            end else begin
                logic signed [15:0] exp_v;
                exp_v = sb_q.pop_front();
                if ($signed(ifc.mix_out) !== exp_v) begin
                    errors++;
                    $display("FAIL mix_out: got %0d expected %0d", $signed(ifc.mix_out), exp_v);
                end
            end
        end
    end

    // Tick once with the current inputs; check latency and busy window.
    task automatic run_mix(input string name);
        int n;
        int busy_cnt;
        apply_inputs();
        @(negedge clk);
        ifc.audio_clk_en = 1'b1;
        sb_q.push_back(model_mix());
        @(negedge clk);
        ifc.audio_clk_en = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (ifc.mix_valid !== 1'b1 && n < 20) begin
            if (ifc.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges expected 5", name, n);
        end
        checks++;
        if (busy_cnt != 5 || ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: high for %0d cycles (busy now %b) expected 5 then 0",
                     name, busy_cnt, ifc.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.mix_out !== 16'd0 || ifc.mix_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%0d valid=%b busy=%b ovr=%b expected 0/0/0/0",
                     $signed(ifc.mix_out), ifc.mix_valid, ifc.busy, ifc.overrun);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (ifc.mix_out !== 16'd0 || ifc.mix_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.overrun !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: cycle %0d out=%0d valid=%b busy=%b ovr=%b expected all 0",
                         i, $signed(ifc.mix_out), ifc.mix_valid, ifc.busy, ifc.overrun);
            end
        end
    endtask

    task automatic test_unity();
        clear_inputs();
        ch[0] = 16'sd1000; g[0] = 8'd128;
        run_mix("unity");
    endtask

    task automatic test_rounding();
        clear_inputs();
        ch[0] = 16'sd3;     g[0] = 8'd64;  run_mix("round_pos");
        ch[0] = -16'sd3;    g[0] = 8'd64;  run_mix("round_neg");
        ch[0] = -16'sd1000; g[0] = 8'd255; run_mix("round_255");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < NUM_CH; k++) begin ch[k] = 16'sd20000;  g[k] = 8'd128; end
        run_mix("sat_pos");
        for (int k = 0; k < NUM_CH; k++) begin ch[k] = -16'sd20000; g[k] = 8'd128; end
        run_mix("sat_neg");
    endtask

    task automatic test_mixed_patterns();
        ch[0] = 16'sd100; ch[1] = -16'sd200; ch[2] = 16'sd300; ch[3] = 16'sd50;
        g[0]  = 8'd128;   g[1]  = 8'd64;     g[2]  = 8'd32;    g[3]  = 8'd200;
        run_mix("mixed_fixed");
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch[k] = 16'($urandom);
                g[k]  = 8'($urandom_range(0, 255));
            end
            run_mix("mixed_rand");
        end
    endtask

    task automatic test_overrun();
        int n;
        clear_inputs();
        ch[0] = 16'sd1000; g[0] = 8'd128;
        apply_inputs();
        @(negedge clk);
        ifc.audio_clk_en = 1'b1;
        sb_q.push_back(model_mix());
        @(negedge clk);
        ifc.audio_clk_en = 1'b0;
        ch[0] = 16'sd2000;
        apply_inputs();
        @(negedge clk);
        ifc.audio_clk_en = 1'b1;
        @(negedge clk);
        ifc.audio_clk_en = 1'b0;
        checks++;
        if (ifc.overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", ifc.overrun);
        end
        n = 2;
        while (ifc.mix_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL overrun_latency: got %0d edges expected 5", n);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (ifc.overrun !== 1'b1 || ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: ovr=%b busy=%b expected 1/0 (dropped tick must not start a mix)",
                     ifc.overrun, ifc.busy);
        end
        run_mix("after_overrun");
    endtask

    task automatic test_reset_mid_mac();
        clear_inputs();
        ch[0] = 16'sd1234; g[0] = 8'd128;
        apply_inputs();
        @(negedge clk);
        ifc.audio_clk_en = 1'b1;
        @(negedge clk);
        ifc.audio_clk_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (ifc.busy !== 1'b0 || ifc.mix_valid !== 1'b0 || ifc.mix_out !== 16'd0 || ifc.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mac: busy=%b valid=%b out=%0d ovr=%b expected 0/0/0/0",
                     ifc.busy, ifc.mix_valid, $signed(ifc.mix_out), ifc.overrun);
        end
        repeat (10) @(negedge clk);
        run_mix("after_reset");
    endtask

`ifdef DK_AUDIO_MIX_MUTE_EN
    task automatic test_mute();
        clear_inputs();
        ch[0] = 16'sd1000; g[0] = 8'd128;
        ch[1] = 16'sd500;  g[1] = 8'd128;
        mute  = 4'b0001;
        run_mix("mute");
        mute  = '0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        ifc.audio_clk_en = 1'b0;
        clear_inputs();
        test_reset();
        test_unity();
        test_rounding();
        test_saturation();
        test_mixed_patterns();
        test_overrun();
        test_reset_mid_mac();
`ifdef DK_AUDIO_MIX_MUTE_EN
        test_mute();
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d mixes never produced, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
